// File: rtl/uart_tx_linjuan_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_linjuan_pkg
//   Shared UART line definitions for the transmit block and the matching
//   receive block: default bit period, data width, line levels and frame
//   lengths for both parity settings.
//
//   Build option: UART_TX_PARITY_EN
//     defined   -> even parity bit after d[7], FRAME_BITS = 11
//     undefined -> no parity bit,               FRAME_BITS = 10
// ---------------------------------------------------------------------------
package uart_tx_linjuan_pkg;

  localparam int   DEFAULT_T            = 5208;  // 50 MHz / 9600 baud
  localparam int   DATA_BITS            = 8;
  localparam logic BIT_IDLE             = 1'b1;
  localparam logic BIT_START            = 1'b0;
  localparam int   FRAME_BITS_NO_PARITY = 10;    // start + 8 data + stop
  localparam int   FRAME_BITS_PARITY    = 11;    // start + 8 data + parity + stop

`ifdef UART_TX_PARITY_EN
  localparam int   FRAME_BITS           = FRAME_BITS_PARITY;
`else
  localparam int   FRAME_BITS           = FRAME_BITS_NO_PARITY;
`endif

  // Transmitter control state: idle line, or a frame on the line.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
//   Bit-timing counter pair for the UART transmitter.
//   cnt0 counts clocks 0..T-1 within a bit while en is high;
//   cnt1 counts bits 0..N-1 and advances on each end_cnt0.
//
//   Ports
//     clk      in  system clock
//     rst_n    in  asynchronous active-low reset
//     en       in  count enable (frame on the line)
//     end_cnt0 out last clock of the current bit
//     end_cnt1 out last clock of the last bit of the frame
// ---------------------------------------------------------------------------
module uart_baud_cnt
  import uart_tx_linjuan_pkg::*;
#(
  parameter int T = DEFAULT_T,  // clocks per bit, 4..8191
  parameter int N = FRAME_BITS  // bits per frame
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic end_cnt0,
  output logic end_cnt1
);

  localparam int                CNT1_W    = $clog2(N);
  localparam logic [12:0]       CNT0_LAST = 13'(T - 1);
  localparam logic [CNT1_W-1:0] CNT1_LAST = CNT1_W'(N - 1);

  logic [12:0]       cnt0;
  logic [CNT1_W-1:0] cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
    end else if (en) begin
      cnt0 <= end_cnt0 ? '0 : cnt0 + 13'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
    end else if (end_cnt0) begin
      cnt1 <= end_cnt1 ? '0 : cnt1 + CNT1_W'(1);
    end
  end

  assign end_cnt0 = en && (cnt0 == CNT0_LAST);
  assign end_cnt1 = end_cnt0 && (cnt1 == CNT1_LAST);

endmodule

// File: rtl/uart_tx_linjuan.sv
// ---------------------------------------------------------------------------
// uart_tx_linjuan
//   8N1 UART transmitter (optionally 8E1) with a one-byte holding register so
//   the next byte can be accepted while the current frame shifts out.
//
//   Handshake: a byte transfers on a rising clk edge where din_vld && din_rdy
//   are both high; din_rdy depends only on registered state, and din_vld may
//   stay high while din_rdy is low without any effect.
//
//   Build option: UART_TX_PARITY_EN (even parity bit after d[7]).
//
//   Ports
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     din      in   byte to send
//     din_vld  in   din holds a valid byte
//     din_rdy  out  holding register empty
//     tx_uart  out  serial line, idle high, registered
//     busy     out  a frame is on the line
// ---------------------------------------------------------------------------
module uart_tx_linjuan
  import uart_tx_linjuan_pkg::*;
#(
  parameter int T = DEFAULT_T
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic       tx_uart,
  output logic       busy
);

  tx_state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]      hold_q;
  logic                      hold_full_q;
  logic [FRAME_BITS-2:0]     shift_q;     // frame bits still to be driven
  logic [FRAME_BITS-1:0]     frame_w;     // full frame built from hold_q
  logic                      accept;
  logic                      launch;
  logic                      end_cnt0;
  logic                      end_cnt1;

  assign din_rdy = !hold_full_q;
  assign accept  = din_vld && din_rdy;

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hold_full_q)               state_d = ST_BUSY;
      ST_BUSY: if (end_cnt1 && !hold_full_q)  state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // ---- state outputs ----
  // A frame starts from an idle line, or back-to-back on the last clock of
  // the previous frame so no idle bit appears between frames.
  always_comb begin
    busy   = (state_q == ST_BUSY);
    launch = hold_full_q && ((state_q == ST_IDLE) || end_cnt1);
  end

  // Frame laid out LSB first: bit 0 is the start bit.
  always_comb begin
`ifdef UART_TX_PARITY_EN
    frame_w = {BIT_IDLE, ^hold_q, hold_q, BIT_START};
`else
    frame_w = {BIT_IDLE, hold_q, BIT_START};
`endif
  end

  uart_baud_cnt #(
    .T (T),
    .N (FRAME_BITS)
  ) u_baud_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (busy),
    .end_cnt0 (end_cnt0),
    .end_cnt1 (end_cnt1)
  );

  // ---- holding register ----
  // accept and launch are mutually exclusive (accept needs an empty hold,
  // launch a full one), so accept taking priority is only a safe default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (accept) hold_q <= din;
      if (accept)      hold_full_q <= 1'b1;
      else if (launch) hold_full_q <= 1'b0;
    end
  end

  // ---- shifter and line register ----
  // The line only changes at bit boundaries or on a launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '1;
      tx_uart <= BIT_IDLE;
    end else if (launch) begin
      shift_q <= frame_w[FRAME_BITS-1:1];
      tx_uart <= frame_w[0];
    end else if (end_cnt1) begin
      shift_q <= '1;
      tx_uart <= BIT_IDLE;
    end else if (end_cnt0) begin
      shift_q <= {BIT_IDLE, shift_q[FRAME_BITS-2:1]};
      tx_uart <= shift_q[0];
    end
  end

endmodule

// File: tb/tb_uart_tx_linjuan.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_linjuan
//   Directed bench for uart_tx_linjuan at T=4 clocks per bit.
// ---------------------------------------------------------------------------
module tb_uart_tx_linjuan;

  localparam int T = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  // Frames written LSB first: {stop, parity, data, start}
  localparam logic [10:0] F_55 = 11'b1_0_01010101_0;
  localparam logic [10:0] F_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] F_3C = 11'b1_0_00111100_0;
  localparam logic [10:0] F_07 = 11'b1_1_00000111_0;
  localparam logic [10:0] F_03 = 11'b1_0_00000011_0;
`else
  localparam int NB = 10;
  // Frames written LSB first: {stop, data, start}
  localparam logic [10:0] F_55 = {1'b0, 10'b1_01010101_0};
  localparam logic [10:0] F_A5 = {1'b0, 10'b1_10100101_0};
  localparam logic [10:0] F_3C = {1'b0, 10'b1_00111100_0};
`endif
  localparam int FL = NB * T;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_vld;
  logic       din_rdy;
  logic       tx_uart;
  logic       busy;

  int vec_cnt;
  int err_cnt;

  uart_tx_linjuan #(.T(T)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_vld (din_vld),
    .din_rdy (din_rdy),
    .tx_uart (tx_uart),
    .busy    (busy)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- driver ----
  // Presents one byte and returns just after the accepting edge.
  task automatic accept_byte(input logic [7:0] b);
    int n;
    din     = b;
    din_vld = 1'b1;
    n = 0;
    while (!din_rdy && n < 200) begin
      step();
      n++;
    end
    vec_cnt++;
    if (!din_rdy) begin
      err_cnt++;
      $display("FAIL accept_wait: din_rdy=%b required 1 within 200 clks", din_rdy);
    end
    step();
    din_vld = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n   = 1'b0;
    din     = 8'h00;
    din_vld = 1'b0;
    step();
    step();
    vec_cnt++;
    if (tx_uart !== 1'b1 || busy !== 1'b0 || din_rdy !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_hold: tx=%b busy=%b rdy=%b required 1 0 1", tx_uart, busy, din_rdy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      vec_cnt++;
      if (tx_uart !== 1'b1 || busy !== 1'b0 || din_rdy !== 1'b1) begin
        err_cnt++;
        $display("FAIL reset_idle clk %0d: tx=%b busy=%b rdy=%b required 1 0 1",
                 i, tx_uart, busy, din_rdy);
      end
    end
  endtask

  // One byte on an idle line: checks one-clock launch latency, every clock
  // of the frame, and the return to idle.
  task automatic test_frame(input logic [7:0] b, input logic [10:0] frame, input string name);
    accept_byte(b);
    vec_cnt++;
    if (tx_uart !== 1'b1 || busy !== 1'b0 || din_rdy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_latency: tx=%b busy=%b rdy=%b required 1 0 0", name, tx_uart, busy, din_rdy);
    end
    step();
    for (int s = 0; s < FL; s++) begin
      vec_cnt++;
      if (tx_uart !== frame[s / T] || busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL %s clk %0d: tx=%b busy=%b required %b 1", name, s, tx_uart, busy, frame[s / T]);
      end
      step();
    end
    vec_cnt++;
    if (tx_uart !== 1'b1 || busy !== 1'b0 || din_rdy !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_end: tx=%b busy=%b rdy=%b required 1 0 1", name, tx_uart, busy, din_rdy);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_tx, exp_busy, exp_rdy;
    accept_byte(8'hA5);
    din     = 8'h3C;
    din_vld = 1'b1;             // held high: taken once the hold frees
    step();                     // launch of 0xA5 -> s = 0
    for (int s = 0; s <= 2 * FL; s++) begin
      if (s < FL)          exp_tx = F_A5[s / T];
      else if (s < 2 * FL) exp_tx = F_3C[(s - FL) / T];
      else                 exp_tx = 1'b1;
      exp_busy = (s < 2 * FL);
      exp_rdy  = (s == 0) || (s >= FL);
      vec_cnt++;
      if (tx_uart !== exp_tx || busy !== exp_busy || din_rdy !== exp_rdy) begin
        err_cnt++;
        $display("FAIL b2b clk %0d: tx=%b busy=%b rdy=%b required %b %b %b",
                 s, tx_uart, busy, din_rdy, exp_tx, exp_busy, exp_rdy);
      end
      if (s == 1) din_vld = 1'b0;
      if (s == 5) din = 8'hFF;  // must not disturb the held 0x3C
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    accept_byte(8'hFF);
    step();                     // s = 0, start bit
    for (int s = 0; s < 4 * T + 1; s++) step();  // inside bit 4
    #3 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (tx_uart !== 1'b1 || busy !== 1'b0 || din_rdy !== 1'b1) begin
      err_cnt++;
      $display("FAIL mid_reset: tx=%b busy=%b rdy=%b required 1 0 1", tx_uart, busy, din_rdy);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    test_frame(8'h55, F_55, "after_reset_55");
  endtask

  // Bench-side receiver: samples mid-bit and rebuilds the byte.
  task automatic test_loopback(input logic [7:0] b);
    logic [7:0] got;
    logic       stop_bit;
    int n;
    got = 8'h00;
    accept_byte(b);
    n = 0;
    while (tx_uart !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    vec_cnt++;
    if (tx_uart !== 1'b0) begin
      err_cnt++;
      $display("FAIL loop_start %02h: tx=%b required 0 within 20 clks", b, tx_uart);
    end
    repeat (T / 2) step();
    for (int i = 0; i < 8; i++) begin
      repeat (T) step();
      got[i] = tx_uart;
    end
`ifdef UART_TX_PARITY_EN
    repeat (T) step();
    vec_cnt++;
    if (tx_uart !== ^b) begin
      err_cnt++;
      $display("FAIL loop_parity %02h: got %b required %b", b, tx_uart, ^b);
    end
`endif
    repeat (T) step();
    stop_bit = tx_uart;
    vec_cnt++;
    if (got !== b || stop_bit !== 1'b1) begin
      err_cnt++;
      $display("FAIL loopback: got %02h stop %b required %02h stop 1", got, stop_bit, b);
    end
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL loop_idle %02h: busy=%b required 0 within 20 clks", b, busy);
    end
  endtask

  // ---- sequence and report ----
  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_frame(8'h55, F_55, "frame_55");
    step();
    test_back_to_back();
    step();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    step();
    test_frame(8'h07, F_07, "parity_07");
    test_frame(8'h03, F_03, "parity_03");
`endif
    test_loopback(8'hA5);
    test_loopback(8'h00);
    test_loopback(8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
